// File: rtl/nn_pkg.sv
// Shared definitions for the layer controllers: sequencer state encoding and
// a width helper that never returns zero.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PRIME = 3'd2,
    ST_ACCUM = 3'd3,
    ST_FLUSH = 3'd4,
    ST_EMIT  = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Runs one fully-connected layer on an external MAC: per neuron it clears the
// MAC, streams input/weight pairs from sync-read memories, flushes, and emits.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_INPUTS  = 3,
  parameter int N_NEURONS = 4,
  localparam int IA_W = clog2_min1(N_INPUTS),
  localparam int WA_W = clog2_min1(N_INPUTS * N_NEURONS),
  localparam int NI_W = clog2_min1(N_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IA_W-1:0]  in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic [WA_W-1:0]  w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             mac_reset,
  output logic             mac_en,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  input  logic [WIDTH-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [NI_W-1:0]  res_idx
);

  localparam logic [WA_W-1:0] W_STEP    = WA_W'(N_INPUTS);
  localparam logic [IA_W-1:0] LAST_IN   = IA_W'(N_INPUTS - 1);
  localparam logic [NI_W-1:0] LAST_NEUR = NI_W'(N_NEURONS - 1);

  seq_state_t       state_q;
  logic [NI_W-1:0]  neuron_q;
  logic [IA_W-1:0]  cnt_q;
  logic [IA_W-1:0]  in_addr_q;
  logic [WA_W-1:0]  w_addr_q;
  logic [WA_W-1:0]  base_q;
  logic             mac_reset_q;
  logic             mac_en_q;
  logic [WIDTH-1:0] mac_a_q;
  logic [WIDTH-1:0] mac_b_q;
  logic             done_q;

  // Outputs are computed for the state being entered, so every strobe is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      neuron_q    <= '0;
      cnt_q       <= '0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      base_q      <= '0;
      mac_reset_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      mac_reset_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_CLEAR;
            neuron_q    <= '0;
            base_q      <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            mac_reset_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q   <= ST_PRIME;
          cnt_q     <= '0;
          in_addr_q <= IA_W'(1);
          w_addr_q  <= base_q + WA_W'(1);
        end
        ST_PRIME: begin
          // Data for i=0 is on the memory outputs now; capture it as the first operand pair.
          state_q   <= ST_ACCUM;
          mac_en_q  <= 1'b1;
          mac_a_q   <= in_data;
          mac_b_q   <= w_data;
          in_addr_q <= in_addr_q + IA_W'(1);
          w_addr_q  <= w_addr_q + WA_W'(1);
        end
        ST_ACCUM: begin
          mac_en_q <= 1'b1;
          if (cnt_q == LAST_IN) begin
            state_q <= ST_FLUSH;
          end else begin
            cnt_q     <= cnt_q + IA_W'(1);
            mac_a_q   <= in_data;
            mac_b_q   <= w_data;
            in_addr_q <= in_addr_q + IA_W'(1);
            w_addr_q  <= w_addr_q + WA_W'(1);
          end
        end
        ST_FLUSH: begin
          state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (res_ready) begin
            if (neuron_q == LAST_NEUR) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_CLEAR;
              neuron_q    <= neuron_q + NI_W'(1);
              base_q      <= base_q + W_STEP;
              in_addr_q   <= '0;
              w_addr_q    <= base_q + W_STEP;
              mac_reset_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign mac_reset = mac_reset_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = (state_q == ST_EMIT);
  // The MAC output register only settles after the flush edge, so it is passed through rather than captured.
  assign res_data  = (state_q == ST_EMIT) ? mac_out : '0;
  assign res_idx   = neuron_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with a behavioural Q2.6 MAC and
// synchronous-read input/weight memories.
module tb_layer_sequencer;

  localparam int WIDTH = 8;
  localparam int IA_W  = 2;
  localparam int WA_W  = 4;
  localparam int NI_W  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic [IA_W-1:0]  in_addr;
  logic [WIDTH-1:0] in_data;
  logic [WA_W-1:0]  w_addr;
  logic [WIDTH-1:0] w_data;
  logic             mac_reset;
  logic             mac_en;
  logic [WIDTH-1:0] mac_a;
  logic [WIDTH-1:0] mac_b;
  logic [WIDTH-1:0] mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [NI_W-1:0]  res_idx;

  layer_sequencer #(.WIDTH(8), .N_INPUTS(3), .N_NEURONS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .mac_reset(mac_reset), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  // Memories
  logic [WIDTH-1:0] in_mem [0:3];
  logic [WIDTH-1:0] w_mem  [0:15];
  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
  end

  // MAC model: Q2.6, output register lags the sum by one enable, ReLU + clamp
  logic signed [19:0] acc;
  logic signed [7:0]  sa, sb;
  logic               mac_clr;
  assign sa = mac_a;
  assign sb = mac_b;
  assign mac_clr = reset | mac_reset;

  function automatic logic [7:0] relu_sat(input logic signed [19:0] v);
    logic signed [19:0] sh;
    sh = v >>> 6;
    if (sh < 0) return 8'h00;
    if (sh > 20'sd127) return 8'h7F;
    return sh[7:0];
  endfunction

  always @(posedge clk or posedge mac_clr) begin
    if (mac_clr) begin
      acc     <= '0;
      mac_out <= '0;
    end else if (mac_en) begin
      acc     <= acc + sa * sb;
      mac_out <= relu_sat(acc);
    end
  end

  // Scoreboard
  typedef struct {
    logic [NI_W-1:0]  idx;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [NI_W-1:0]  held_idx;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_data", 32'(res_data), 32'(held_data));
        chk("stall_idx", 32'(res_idx), 32'(held_idx));
      end
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(res_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("res_idx", 32'(res_idx), 32'(e.idx));
          chk("res_data", 32'(res_data), 32'(e.data));
        end
      end
      stall_prev = res_valid && !res_ready;
      held_data  = res_data;
      held_idx   = res_idx;
      if (done) done_cnt++;
    end
  end

  // Set 0: mixed vectors, results 70/00/38/30. Set 1: all 0x7F, saturates.
  task automatic load_set(input int set);
    logic [7:0] wa [0:11];
    if (set == 0) begin
      in_mem[0] = 8'h40; in_mem[1] = 8'h20; in_mem[2] = 8'h10; in_mem[3] = 8'h00;
      wa = '{8'h40, 8'h40, 8'h40, 8'hC0, 8'hC0, 8'hC0,
             8'h20, 8'h20, 8'h20, 8'h40, 8'h00, 8'hC0};
    end else begin
      for (int i = 0; i < 4; i++) in_mem[i] = 8'h7F;
      for (int i = 0; i < 12; i++) wa[i] = 8'h7F;
    end
    for (int i = 0; i < 12; i++) w_mem[i] = wa[i];
    for (int i = 12; i < 16; i++) w_mem[i] = 8'h00;
  endtask

  task automatic push_set(input int set);
    logic [7:0] r [0:3];
    exp_t x;
    if (set == 0) r = '{8'h70, 8'h00, 8'h38, 8'h30};
    else          r = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    for (int i = 0; i < 4; i++) begin
      x.idx  = NI_W'(i);
      x.data = r[i];
      sb_q.push_back(x);
    end
  endtask

  task automatic run_pass(input string tag, input int stall_idx, input int stall_len,
                          input int exp_cyc, input int extra_start_at);
    int cyc;
    int stalls;
    int d0;
    d0 = done_cnt;
    stalls = stall_len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      start = (cyc == extra_start_at);
      if (res_valid && (int'(res_idx) == stall_idx) && stalls > 0) begin
        res_ready = 1'b0;
        stalls--;
      end else begin
        res_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    @(posedge clk); #1;
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {27'd0, busy, done, mac_reset, mac_en, res_valid}, 32'd0);
    chk({tag, "_data"}, {8'd0, mac_a, mac_b, res_data}, 32'd0);
    chk({tag, "_addr"}, {24'd0, in_addr, w_addr, res_idx}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    load_set(0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic + ReLU + mixed signs, ready always high
    push_set(0);
    run_pass("basic", -1, 0, 29, -1);

    // Saturation, with a stray start pulse mid-pass
    load_set(1);
    push_set(1);
    run_pass("sat_ign_start", -1, 0, 29, 10);

    // Backpressure on neuron 2
    load_set(0);
    push_set(0);
    run_pass("backpressure", 2, 5, 34, -1);

    // Reset in neuron 1 ACCUM (cycles 10..12)
    begin
      exp_t x;
      int d0;
      x.idx = '0;
      x.data = 8'h70;
      sb_q.push_back(x);
      d0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin
        @(posedge clk); #1;
      end
      chk("pre_reset_accum", {30'd0, mac_en, res_idx == 2'd1}, 32'd3);
      reset = 1'b1;
      #1;
      chk_reset_vals("async_reset");
      @(posedge clk); #1;
      chk_reset_vals("held_reset");
      reset = 1'b0;
      chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
      chk("reset_sb_drained", 32'(sb_q.size()), 32'd0);
      @(posedge clk); #1;
    end
    push_set(0);
    run_pass("after_reset", -1, 0, 29, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
